toll_collector: RTL and testbench

Payment-side counterpart of the toll calculator. It latches the toll due (in cents) when a vehicle is presented, accumulates coins, and reports the remaining balance in BCD. It drives TOLL_PAID back to the calculator and raises gate release, or refunds the deposit on cancel or timeout. It sits between the coin acceptor and the toll calculator at each lane.

---
 rtl/toll_collector.sv | 196 +++++++++++++++++++
 tb/tb_toll_collector.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/toll_collector.sv
// toll_collector: latches the toll due, accumulates coins, and shows the remaining balance in BCD.
// When the toll is fully paid it raises TOLL_PAID and reports any change.
// On cancel or timeout it refunds the deposit.
module toll_collector #(
  parameter int unsigned MAX_TOLL  = 999,
  parameter int unsigned PAID_HOLD = 4,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] TOLL,
  input  logic        TOLL_VALID,
  input  logic        COIN_VALID,
  input  logic [2:0]  COIN_TYPE,
  input  logic        CANCEL,
  output logic        TOLL_PAID,
  output logic [15:0] CHANGE_DUE,
  output logic        CHANGE_VALID,
  output logic        COIN_REJECT,
  output logic        BUSY,
  output logic [3:0]  BCD_DOLLARS,
  output logic [3:0]  BCD_CENTS_MSB,
  output logic [3:0]  BCD_CENTS_LSB
);

  localparam int unsigned VAL_W = 16;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PAID    = 2'd2;
  localparam logic [1:0] ST_REFUND  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [VAL_W-1:0] due, due_nxt;
  logic [VAL_W-1:0] paid, paid_nxt;
  logic [VAL_W-1:0] timer, timer_nxt;
  logic             armed, armed_nxt;

  logic             toll_paid_nxt, change_valid_nxt, coin_reject_nxt, busy_nxt;
  logic [VAL_W-1:0] change_due_nxt;
  logic [3:0]       bcd_d_nxt, bcd_m_nxt, bcd_l_nxt;

  logic             show_load;
  logic [VAL_W-1:0] show_val;
  logic [VAL_W-1:0] toll_clamped, coin_val, paid_new;
  logic             coin_legal, coin_illegal;

  assign coin_legal   = COIN_VALID & ~COIN_TYPE[2];
  assign coin_illegal = COIN_VALID &  COIN_TYPE[2];
  assign paid_new     = paid + coin_val;
  assign toll_clamped = (TOLL > VAL_W'(MAX_TOLL)) ? VAL_W'(MAX_TOLL) : TOLL;

  // Coin type to value in cents; illegal types map to zero.
  always_comb begin
    coin_val = '0;
    case (COIN_TYPE)
      3'd0:    coin_val = 16'd5;
      3'd1:    coin_val = 16'd10;
      3'd2:    coin_val = 16'd25;
      3'd3:    coin_val = 16'd100;
      default: coin_val = '0;
    endcase
  end

  // Next state and next registered outputs.
  // In PAID, timer is reused as the hold counter.
  always_comb begin
    state_nxt        = state;
    due_nxt          = due;
    paid_nxt         = paid;
    timer_nxt        = timer;
    armed_nxt        = armed;
    toll_paid_nxt    = TOLL_PAID;
    change_due_nxt   = '0;
    change_valid_nxt = 1'b0;
    coin_reject_nxt  = 1'b0;
    show_load        = 1'b0;
    show_val         = '0;
    bcd_d_nxt        = BCD_DOLLARS;
    bcd_m_nxt        = BCD_CENTS_MSB;
    bcd_l_nxt        = BCD_CENTS_LSB;

    case (state)
      ST_IDLE: begin
        coin_reject_nxt = COIN_VALID;
        if (!TOLL_VALID) armed_nxt = 1'b1;
        if (TOLL_VALID && armed) begin
          armed_nxt = 1'b0;
          due_nxt   = toll_clamped;
          paid_nxt  = '0;
          timer_nxt = '0;
          show_load = 1'b1;
          show_val  = toll_clamped;
          if (toll_clamped == '0) begin
            state_nxt     = ST_PAID;
            toll_paid_nxt = 1'b1;
          end else begin
            state_nxt = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (coin_legal) begin
          paid_nxt  = paid_new;
          timer_nxt = '0;
          show_load = 1'b1;
          if (paid_new >= due) begin
            state_nxt        = ST_PAID;
            toll_paid_nxt    = 1'b1;
            change_due_nxt   = paid_new - due;
            change_valid_nxt = 1'b1;
            show_val         = '0;
          end else if (CANCEL) begin
            state_nxt        = ST_REFUND;
            change_due_nxt   = paid_new;
            change_valid_nxt = 1'b1;
            show_val         = '0;
          end else begin
            show_val = due - paid_new;
          end
        end else begin
          coin_reject_nxt = coin_illegal;
          if (CANCEL || (!coin_illegal && timer == VAL_W'(TIMEOUT - 1))) begin
            state_nxt        = ST_REFUND;
            change_due_nxt   = paid;
            change_valid_nxt = 1'b1;
            show_load        = 1'b1;
            show_val         = '0;
          end else if (!coin_illegal) begin
            timer_nxt = timer + 16'd1;
          end
        end
      end

      ST_PAID: begin
        coin_reject_nxt = COIN_VALID;
        if (!TOLL_VALID) armed_nxt = 1'b1;
        if (timer == VAL_W'(PAID_HOLD - 1)) begin
          state_nxt     = ST_IDLE;
          toll_paid_nxt = 1'b0;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      default: begin
        coin_reject_nxt = COIN_VALID;
        if (!TOLL_VALID) armed_nxt = 1'b1;
        state_nxt = ST_IDLE;
      end
    endcase

    if (show_load) begin
      bcd_d_nxt = 4'(show_val / 16'd100);
      bcd_m_nxt = 4'((show_val / 16'd10) % 16'd10);
      bcd_l_nxt = 4'(show_val % 16'd10);
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      due           <= '0;
      paid          <= '0;
      timer         <= '0;
      armed         <= 1'b1;
      TOLL_PAID     <= 1'b0;
      CHANGE_DUE    <= '0;
      CHANGE_VALID  <= 1'b0;
      COIN_REJECT   <= 1'b0;
      BUSY          <= 1'b0;
      BCD_DOLLARS   <= '0;
      BCD_CENTS_MSB <= '0;
      BCD_CENTS_LSB <= '0;
    end else begin
      state         <= state_nxt;
      due           <= due_nxt;
      paid          <= paid_nxt;
      timer         <= timer_nxt;
      armed         <= armed_nxt;
      TOLL_PAID     <= toll_paid_nxt;
      CHANGE_DUE    <= change_due_nxt;
      CHANGE_VALID  <= change_valid_nxt;
      COIN_REJECT   <= coin_reject_nxt;
      BUSY          <= busy_nxt;
      BCD_DOLLARS   <= bcd_d_nxt;
      BCD_CENTS_MSB <= bcd_m_nxt;
      BCD_CENTS_LSB <= bcd_l_nxt;
    end
  end

endmodule

// File: tb/tb_toll_collector.sv
// Testbench for toll_collector.
// A behavioural lane model is compared against the DUT every cycle.
// Directed scenarios are checked against hand-computed values.
// A randomized phase follows the directed scenarios.
module tb_toll_collector;

  localparam int MAX_TOLL  = 999;
  localparam int PAID_HOLD = 4;
  localparam int TIMEOUT   = 16;

  localparam int PH_IDLE    = 0;
  localparam int PH_COLLECT = 1;
  localparam int PH_PAID    = 2;
  localparam int PH_REFUND  = 3;

  logic        CLK;
  logic        RESET;
  logic [15:0] TOLL;
  logic        TOLL_VALID;
  logic        COIN_VALID;
  logic [2:0]  COIN_TYPE;
  logic        CANCEL;
  logic        TOLL_PAID;
  logic [15:0] CHANGE_DUE;
  logic        CHANGE_VALID;
  logic        COIN_REJECT;
  logic        BUSY;
  logic [3:0]  BCD_DOLLARS;
  logic [3:0]  BCD_CENTS_MSB;
  logic [3:0]  BCD_CENTS_LSB;

  int n_checks = 0;
  int n_errors = 0;

  // Model state, initialized to the post-reset condition.
  int m_phase  = PH_IDLE;
  int m_due    = 0;
  int m_paid   = 0;
  int m_idle   = 0;
  int m_hold   = 0;
  bit m_armed  = 1'b1;
  bit e_tp     = 1'b0;
  bit e_cv     = 1'b0;
  bit e_rej    = 1'b0;
  bit e_busy   = 1'b0;
  int e_change = 0;
  int e_shown  = 0;

  toll_collector #(
    .MAX_TOLL (MAX_TOLL),
    .PAID_HOLD(PAID_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .TOLL         (TOLL),
    .TOLL_VALID   (TOLL_VALID),
    .COIN_VALID   (COIN_VALID),
    .COIN_TYPE    (COIN_TYPE),
    .CANCEL       (CANCEL),
    .TOLL_PAID    (TOLL_PAID),
    .CHANGE_DUE   (CHANGE_DUE),
    .CHANGE_VALID (CHANGE_VALID),
    .COIN_REJECT  (COIN_REJECT),
    .BUSY         (BUSY),
    .BCD_DOLLARS  (BCD_DOLLARS),
    .BCD_CENTS_MSB(BCD_CENTS_MSB),
    .BCD_CENTS_LSB(BCD_CENTS_LSB)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int coin_cents(input logic [2:0] t);
    case (t)
      3'd0:    return 5;
      3'd1:    return 10;
      3'd2:    return 25;
      3'd3:    return 100;
      default: return 0;
    endcase
  endfunction

  task automatic model_refund();
    m_phase  = PH_REFUND;
    e_cv     = 1'b1;
    e_change = m_paid;
    e_shown  = 0;
  endtask

  // Behavioural lane model, advanced on each clock edge or reset.
  initial begin
    bit legal, illegal;
    forever begin
      @(posedge CLK or posedge RESET);
      if (RESET) begin
        m_phase = PH_IDLE; m_due = 0; m_paid = 0; m_idle = 0; m_hold = 0; m_armed = 1'b1;
        e_tp = 0; e_cv = 0; e_rej = 0; e_busy = 0; e_change = 0; e_shown = 0;
      end else begin
        e_cv = 0; e_change = 0; e_rej = 0;
        case (m_phase)
          PH_IDLE: begin
            e_rej = COIN_VALID;
            if (TOLL_VALID && m_armed) begin
              m_armed = 1'b0;
              m_due   = (int'(TOLL) > MAX_TOLL) ? MAX_TOLL : int'(TOLL);
              m_paid  = 0;
              m_idle  = 0;
              e_shown = m_due;
              if (m_due == 0) begin
                m_phase = PH_PAID; m_hold = PAID_HOLD; e_tp = 1'b1;
              end else begin
                m_phase = PH_COLLECT;
              end
            end else if (!TOLL_VALID) begin
              m_armed = 1'b1;
            end
          end
          PH_COLLECT: begin
            legal   = COIN_VALID && (COIN_TYPE < 3'd4);
            illegal = COIN_VALID && !legal;
            e_rej   = illegal;
            if (legal) begin
              m_paid += coin_cents(COIN_TYPE);
              m_idle  = 0;
              if (m_paid >= m_due) begin
                m_phase  = PH_PAID; m_hold = PAID_HOLD;
                e_tp     = 1'b1; e_cv = 1'b1;
                e_change = m_paid - m_due;
                e_shown  = 0;
              end else if (CANCEL) begin
                model_refund();
              end else begin
                e_shown = m_due - m_paid;
              end
            end else if (CANCEL) begin
              model_refund();
            end else if (!illegal) begin
              m_idle++;
              if (m_idle >= TIMEOUT) model_refund();
            end
          end
          PH_PAID: begin
            e_rej = COIN_VALID;
            if (!TOLL_VALID) m_armed = 1'b1;
            m_hold--;
            if (m_hold == 0) begin
              m_phase = PH_IDLE; e_tp = 1'b0;
            end
          end
          default: begin
            e_rej = COIN_VALID;
            if (!TOLL_VALID) m_armed = 1'b1;
            m_phase = PH_IDLE;
          end
        endcase
        e_busy = (m_phase != PH_IDLE);
      end
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    forever begin
      @(negedge CLK);
      check("toll_paid",    32'(TOLL_PAID),     32'(e_tp));
      check("change_valid", 32'(CHANGE_VALID),  32'(e_cv));
      check("change_due",   32'(CHANGE_DUE),    32'(e_change));
      check("coin_reject",  32'(COIN_REJECT),   32'(e_rej));
      check("busy",         32'(BUSY),          32'(e_busy));
      check("bcd_dollars",  32'(BCD_DOLLARS),   32'(e_shown / 100));
      check("bcd_msb",      32'(BCD_CENTS_MSB), 32'((e_shown / 10) % 10));
      check("bcd_lsb",      32'(BCD_CENTS_LSB), 32'(e_shown % 10));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic coin(input int t);
    COIN_VALID = 1'b1;
    COIN_TYPE  = 3'(t);
    step(1);
    COIN_VALID = 1'b0;
  endtask

  task automatic start(input int toll);
    TOLL       = 16'(toll);
    TOLL_VALID = 1'b1;
    step(1);
    TOLL_VALID = 1'b0;
  endtask

  task automatic check_bcd(input string name, input logic [11:0] exp);
    check(name, 32'({BCD_DOLLARS, BCD_CENTS_MSB, BCD_CENTS_LSB}), 32'(exp));
  endtask

  task automatic check_all_zero(input string name);
    check(name, {TOLL_PAID, CHANGE_VALID, COIN_REJECT, BUSY, CHANGE_DUE,
                 BCD_DOLLARS, BCD_CENTS_MSB, BCD_CENTS_LSB}, 32'd0);
  endtask

  // Stimulus: directed scenarios, then randomized traffic.
  initial begin
    int rate;
    RESET = 1'b1; TOLL = '0; TOLL_VALID = 1'b0; COIN_VALID = 1'b0; COIN_TYPE = '0; CANCEL = 1'b0;

    // Reset with random inputs
    for (int i = 0; i < 4; i++) begin
      TOLL       = 16'($urandom);
      TOLL_VALID = 1'($urandom);
      COIN_VALID = 1'($urandom);
      COIN_TYPE  = 3'($urandom);
      CANCEL     = 1'($urandom);
      step(1);
    end
    check_all_zero("reset_outputs");
    RESET = 1'b0; TOLL_VALID = 1'b0; COIN_VALID = 1'b0; CANCEL = 1'b0;
    step(2);

    // Exact payment, TOLL_VALID held high afterwards
    TOLL = 16'd90; TOLL_VALID = 1'b1;
    step(1);
    check_bcd("exact_start", 12'h090);
    coin(2); check_bcd("exact_c1", 12'h065);
    coin(2); check_bcd("exact_c2", 12'h040);
    coin(2); check_bcd("exact_c3", 12'h015);
    coin(1); check_bcd("exact_c4", 12'h005);
    coin(0);
    check_bcd("exact_done_bcd", 12'h000);
    check("exact_paid", 32'(TOLL_PAID), 32'd1);
    check("exact_cv", 32'(CHANGE_VALID), 32'd1);
    check("exact_change", 32'(CHANGE_DUE), 32'd0);
    step(1);
    check("exact_cv_once", 32'(CHANGE_VALID), 32'd0);
    step(2);
    check("exact_paid_hold4", 32'(TOLL_PAID), 32'd1);
    step(1);
    check("exact_paid_drop", 32'(TOLL_PAID), 32'd0);
    step(3);
    check("valid_held_no_restart", 32'(BUSY), 32'd0);
    TOLL_VALID = 1'b0;
    step(1);

    // Overpayment
    start(195);
    check_bcd("over_start", 12'h195);
    coin(3); check_bcd("over_c1", 12'h095);
    coin(3);
    check("over_paid", 32'(TOLL_PAID), 32'd1);
    check("over_change", 32'(CHANGE_DUE), 32'd5);
    step(5);

    // Cancel after one coin
    start(145);
    coin(2);
    check_bcd("cancel_bal", 12'h120);
    CANCEL = 1'b1; step(1); CANCEL = 1'b0;
    check("cancel_cv", 32'(CHANGE_VALID), 32'd1);
    check("cancel_change", 32'(CHANGE_DUE), 32'd25);
    check("cancel_not_paid", 32'(TOLL_PAID), 32'd0);
    step(1);
    check("cancel_idle", 32'(BUSY), 32'd0);

    // Cancel together with a completing coin
    start(90);
    CANCEL = 1'b1; coin(3); CANCEL = 1'b0;
    check("cancel_coin_paid", 32'(TOLL_PAID), 32'd1);
    check("cancel_coin_change", 32'(CHANGE_DUE), 32'd10);
    step(5);

    // Timeout with no coins
    start(30);
    step(15);
    check("timeout_not_yet", 32'(CHANGE_VALID), 32'd0);
    step(1);
    check("timeout_cv", 32'(CHANGE_VALID), 32'd1);
    check("timeout_change", 32'(CHANGE_DUE), 32'd0);
    step(1);

    // Coin at cycle 10 restarts the timeout count
    start(30);
    step(9);
    coin(0);
    check_bcd("timeout_coin_bal", 12'h025);
    step(15);
    check("timeout_restart_not_yet", 32'(CHANGE_VALID), 32'd0);
    step(1);
    check("timeout_restart_cv", 32'(CHANGE_VALID), 32'd1);
    check("timeout_restart_change", 32'(CHANGE_DUE), 32'd5);
    step(1);

    // Illegal coin in COLLECT
    start(50);
    coin(5);
    check("illegal_reject", 32'(COIN_REJECT), 32'd1);
    check_bcd("illegal_bal", 12'h050);
    CANCEL = 1'b1; step(1); CANCEL = 1'b0;
    step(1);

    // Zero toll goes straight to PAID
    start(0);
    check("zero_paid", 32'(TOLL_PAID), 32'd1);
    check("zero_busy", 32'(BUSY), 32'd1);
    step(4);

    // Toll above ceiling is clamped
    start(1500);
    check_bcd("clamp_bcd", 12'h999);
    CANCEL = 1'b1; step(1); CANCEL = 1'b0;
    step(1);

    // Reset during COLLECT discards the deposit silently
    start(145);
    coin(2);
    RESET = 1'b1;
    #2;
    check_all_zero("reset_mid_outputs");
    step(1);
    RESET = 1'b0;
    step(1);
    check("reset_mid_no_cv", 32'(CHANGE_VALID), 32'd0);
    check("reset_mid_idle", 32'(BUSY), 32'd0);

    // Randomized traffic
    rate = 25;
    for (int i = 0; i < 4000; i++) begin
      if (i % 200 == 0) begin
        case ($urandom_range(0, 3))
          0:       rate = 0;
          1:       rate = 5;
          2:       rate = 25;
          default: rate = 60;
        endcase
      end
      RESET = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) TOLL_VALID = ~TOLL_VALID;
      case ($urandom_range(0, 7))
        0:       TOLL = 16'd0;
        1:       TOLL = 16'($urandom_range(1000, 65535));
        default: TOLL = 16'($urandom_range(1, 400));
      endcase
      COIN_VALID = ($urandom_range(0, 99) < rate);
      COIN_TYPE  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      CANCEL     = ($urandom_range(0, 49) == 0);
      step(1);
    end

    RESET = 1'b0; TOLL_VALID = 1'b0; COIN_VALID = 1'b0; CANCEL = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
